// File: rtl/descrambler_lock_ctrl.sv
// Lane bring-up controller: sequences block sync and descrambler lock, retries
// acquisition with a holdoff between attempts, and gives up after MAX_RETRIES.
module descrambler_lock_ctrl #(
  parameter int LOCK_TIMEOUT   = 256,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int MAX_RETRIES    = 4
) (
  input  logic       USER_CLK,
  input  logic       SYSTEM_RESET_N,
  input  logic       ENABLE,
  input  logic       BLOCK_LOCK,
  input  logic       DESCR_LOCKED,
  output logic       DESCR_DATA_VALID,
  output logic       DESCR_PASSTHROUGH,
  output logic       LANE_UP,
  output logic       LANE_FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT,
  output logic [2:0] STATE
);

  localparam int TIMER_MAX = (LOCK_TIMEOUT > HOLDOFF_CYCLES) ? LOCK_TIMEOUT : HOLDOFF_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX) + 1;

  localparam logic [TW-1:0] ACQ_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLDOFF_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [3:0]    RETRY_LAST = 4'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BLOCK = 3'd1,
    ACQUIRE    = 3'd2,
    UP         = 3'd3,
    HOLDOFF    = 3'd4,
    FAIL       = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q,  loss_d;

  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state_q <= IDLE;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // The timer is cleared on every entry into ACQUIRE or HOLDOFF, so it is
  // only ever compared against the limit of the state that cleared it.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (!ENABLE) begin
      state_d = IDLE;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_BLOCK;
        end
        WAIT_BLOCK: begin
          if (BLOCK_LOCK) begin
            state_d = ACQUIRE;
            timer_d = '0;
          end
        end
        ACQUIRE: begin
          timer_d = timer_q + TIMER_ONE;
          if (DESCR_LOCKED) begin
            state_d = UP;
            retry_d = '0;
          end else if (!BLOCK_LOCK) begin
            state_d = WAIT_BLOCK;
          end else if (timer_q == ACQ_LAST) begin
            retry_d = retry_q + 4'd1;
            timer_d = '0;
            state_d = (retry_q == RETRY_LAST) ? FAIL : HOLDOFF;
          end
        end
        UP: begin
          if (!DESCR_LOCKED || !BLOCK_LOCK) begin
            state_d = HOLDOFF;
            timer_d = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        HOLDOFF: begin
          if (timer_q == HOLD_LAST) begin
            state_d = WAIT_BLOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Moore outputs, decoded from registered state only.
  always_comb begin
    DESCR_DATA_VALID  = (state_q == ACQUIRE) || (state_q == UP);
    DESCR_PASSTHROUGH = !((state_q == ACQUIRE) || (state_q == UP));
    LANE_UP           = (state_q == UP);
    LANE_FAIL         = (state_q == FAIL);
    RETRY_CNT         = retry_q;
    LOSS_CNT          = loss_q;
    STATE             = state_q;
  end

endmodule

// File: tb/tb_descrambler_lock_ctrl.sv
// Self-checking bench for descrambler_lock_ctrl: table vectors, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_descrambler_lock_ctrl;

  localparam int LT = 8;
  localparam int HC = 4;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       enable = 1'b0;
  logic       blockLock = 1'b0;
  logic       descrLocked = 1'b0;
  logic       dataValid, passthrough, laneUp, laneFail;
  logic [3:0] retryCnt;
  logic [7:0] lossCnt;
  logic [2:0] stateOut;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number plus cycles spent in the current timed phase.
  int mState, mRetry, mLoss, mCycles;

  typedef struct {
    logic en;
    logic bl;
    logic dl;
    int   reps;
    int   expState;
    int   expRetry;
    int   expLoss;
  } vec_t;

  vec_t vecs[$];

  descrambler_lock_ctrl #(
    .LOCK_TIMEOUT  (LT),
    .HOLDOFF_CYCLES(HC),
    .MAX_RETRIES   (MR)
  ) dut (
    .USER_CLK         (clk),
    .SYSTEM_RESET_N   (rstN),
    .ENABLE           (enable),
    .BLOCK_LOCK       (blockLock),
    .DESCR_LOCKED     (descrLocked),
    .DESCR_DATA_VALID (dataValid),
    .DESCR_PASSTHROUGH(passthrough),
    .LANE_UP          (laneUp),
    .LANE_FAIL        (laneFail),
    .RETRY_CNT        (retryCnt),
    .LOSS_CNT         (lossCnt),
    .STATE            (stateOut)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mState  = 0;
    mRetry  = 0;
    mLoss   = 0;
    mCycles = 0;
  endtask

  // Phases: 0 idle, 1 wait block, 2 acquire, 3 up, 4 holdoff, 5 fail.
  task automatic modelStep(input logic en, input logic bl, input logic dl);
    if (!en) begin
      mState  = 0;
      mRetry  = 0;
      mCycles = 0;
    end else begin
      case (mState)
        0: mState = 1;
        1: if (bl) begin mState = 2; mCycles = 0; end
        2: begin
          mCycles++;
          if (dl) begin
            mState = 3;
            mRetry = 0;
          end else if (!bl) begin
            mState = 1;
          end else if (mCycles == LT) begin
            mRetry++;
            mState  = (mRetry == MR) ? 5 : 4;
            mCycles = 0;
          end
        end
        3: if (!dl || !bl) begin
          mState  = 4;
          mCycles = 0;
          mLoss   = (mLoss < 255) ? mLoss + 1 : 255;
        end
        4: begin
          mCycles++;
          if (mCycles == HC) begin mState = 1; mCycles = 0; end
        end
        default: mState = mState;
      endcase
    end
  endtask

  function automatic logic [18:0] expectedVector(input int s, input int r, input int l);
    logic [2:0] s3;
    logic [3:0] r4;
    logic [7:0] l8;
    logic       dv;
    s3 = 3'(s);
    r4 = 4'(r);
    l8 = 8'(l);
    dv = (s == 2) || (s == 3);
    return {s3, dv, !dv, (s == 3), (s == 5), r4, l8};
  endfunction

  task automatic checkOutput(input string name, input int s, input int r, input int l);
    logic [18:0] act, exp;
    act = {stateOut, dataValid, passthrough, laneUp, laneFail, retryCnt, lossCnt};
    exp = expectedVector(s, r, l);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d dv=%b pt=%b up=%b fail=%b retry=%0d loss=%0d, expected state=%0d dv=%b pt=%b up=%b fail=%b retry=%0d loss=%0d",
               name, act[18:16], act[15], act[14], act[13], act[12], act[11:8], act[7:0],
               exp[18:16], exp[15], exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  // Drive inputs, take one clock edge, and advance the model with the same inputs.
  task automatic applyStimulus(input logic en, input logic bl, input logic dl);
    enable      = en;
    blockLock   = bl;
    descrLocked = dl;
    @(posedge clk);
    #1;
    modelStep(en, bl, dl);
  endtask

  task automatic cycleCheck(input string name, input logic en, input logic bl, input logic dl);
    applyStimulus(en, bl, dl);
    checkOutput(name, mState, mRetry, mLoss);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rstN        = 1'b0;
    enable      = 1'b0;
    blockLock   = 1'b0;
    descrLocked = 1'b0;
    #1;
    checkOutput("reset_state", 0, 0, 0);
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
  endtask

  initial begin
    modelReset();

    // Bring-up to UP, then a full timeout/holdoff/fail sequence.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 2, 1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 2, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3, 2, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2, 3, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1, 0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 1, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 2, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 7, 2, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 4, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3, 4, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 1, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 2, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 7, 2, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 5, 2, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 2, 5, 2, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1, 0, 0, 0});

    #1;
    checkOutput("reset_initial", 0, 0, 0);
    #12;
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        applyStimulus(vecs[i].en, vecs[i].bl, vecs[i].dl);
        checkOutput($sformatf("vec%0d_%0d", i, k), vecs[i].expState, vecs[i].expRetry, vecs[i].expLoss);
      end
    end

    // Lock arrives on the very cycle the acquisition timer expires.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < LT - 1; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("acq_timer7", 2, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("lock_at_timeout", 3, 0, 0);

    // Block lock lost during ACQUIRE after one timeout: back to WAIT_BLOCK, retry kept.
    doReset();
    for (int k = 0; k < 2 + LT + HC + 1; k++) cycleCheck("pre_bl_drop", 1'b1, 1'b1, 1'b0);
    checkOutput("second_acquire", 2, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("bl_drop", 1, 1, 0);

    // Repeated lock loss from UP until the loss counter saturates.
    doReset();
    cycleCheck("to_wait", 1'b1, 1'b1, 1'b1);
    cycleCheck("to_acq", 1'b1, 1'b1, 1'b1);
    cycleCheck("to_up", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      cycleCheck("loss_drop", 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < HC + 2; k++) cycleCheck("relock", 1'b1, 1'b1, 1'b1);
    end
    checkOutput("loss_saturated", 3, 0, 255);

    // Reset asserted between edges while UP must act without a clock.
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_up", 0, 0, 0);
    @(negedge clk);
    rstN = 1'b1;
    modelReset();

    // Randomized traffic checked against the model.
    for (int i = 0; i < 3000; i++) begin
      logic en, bl, dl;
      en = ($urandom_range(63) != 0);
      bl = ($urandom_range(15) != 0);
      dl = ($urandom_range(23) == 0);
      if (mState == 3) dl = ($urandom_range(7) != 0);
      cycleCheck("random", en, bl, dl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
